// File: rtl/pl_stage_pkg.sv
// Shared types for the elastic pipeline stage and the CPU control bundles carried through it;
// each stage instance sizes CTRL_W with $bits of the matching bundle.
package pl_stage_pkg;

  localparam int PL_CNT_W_DFLT = 32;

  typedef logic [1:0] pl_occ_t;

  typedef enum logic [1:0] {
    PL_EMPTY = 2'd0,
    PL_ONE   = 2'd1,
    PL_TWO   = 2'd2
  } pl_state_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic branch;
  } mem_ctrl_t;

  typedef struct packed {
    logic       alu_src;
    logic [1:0] alu_op;
    logic       reg_dst;
  } ex_ctrl_t;

endpackage

// File: rtl/pl_stage_slot.sv
// One pipeline entry (valid + ctrl + data), loaded on the clock edge after i_load.
// Squash clears valid and ctrl but keeps data, and overrides both load and clear.
module pl_stage_slot #(
  parameter int                CTRL_W   = 8,
  parameter int                DATA_W   = 128,
  parameter logic [CTRL_W-1:0] CTRL_RST = '0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic              i_squash,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_ctrl  <= CTRL_RST;
      r_data  <= '0;
    end else if (i_squash) begin
      r_valid <= 1'b0;
      r_ctrl  <= CTRL_RST;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_ctrl  <= i_ctrl;
      r_data  <= i_data;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_ctrl  = r_ctrl;
  assign o_data  = r_data;

endmodule

// File: rtl/pl_stage_elastic.sv
// Generic elastic pipeline stage register: 1-cycle latency, 1 item/cycle throughput.
// Backpressure: registered in_ready via a 2-entry skid (SKID=1) or combinational ready (SKID=0).
module pl_stage_elastic
  import pl_stage_pkg::*;
#(
  parameter int                CTRL_W   = 8,
  parameter int                DATA_W   = 128,
  parameter logic [CTRL_W-1:0] CTRL_RST = '0,
  parameter int                SKID     = 1,
  parameter int                CNT_W    = PL_CNT_W_DFLT
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  pl_state_t         r_state;
  pl_state_t         w_state_nxt;
  logic              w_acc;
  logic              w_fire;
  logic              w_in_ready;
  logic              w_main_load;
  logic              w_main_clear;
  logic              w_main_valid;
  logic [CTRL_W-1:0] w_main_ctrl_in;
  logic [DATA_W-1:0] w_main_data_in;
  logic [CTRL_W-1:0] w_main_ctrl;
  logic [DATA_W-1:0] w_main_data;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_bubble_cnt;

  assign w_acc  = in_valid && w_in_ready;
  assign w_fire = w_main_valid && out_ready;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= PL_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  pl_stage_slot #(
    .CTRL_W   (CTRL_W),
    .DATA_W   (DATA_W),
    .CTRL_RST (CTRL_RST)
  ) u_main (
    .i_clk    (CLK),
    .i_rst_n  (nRST),
    .i_load   (w_main_load),
    .i_clear  (w_main_clear),
    .i_squash (flush),
    .i_ctrl   (w_main_ctrl_in),
    .i_data   (w_main_data_in),
    .o_valid  (w_main_valid),
    .o_ctrl   (w_main_ctrl),
    .o_data   (w_main_data)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic              w_skid_load;
      logic              w_skid_clear;
      logic              w_skid_valid;
      logic [CTRL_W-1:0] w_skid_ctrl;
      logic [DATA_W-1:0] w_skid_data;

      pl_stage_slot #(
        .CTRL_W   (CTRL_W),
        .DATA_W   (DATA_W),
        .CTRL_RST (CTRL_RST)
      ) u_skid (
        .i_clk    (CLK),
        .i_rst_n  (nRST),
        .i_load   (w_skid_load),
        .i_clear  (w_skid_clear),
        .i_squash (flush),
        .i_ctrl   (in_ctrl),
        .i_data   (in_data),
        .o_valid  (w_skid_valid),
        .o_ctrl   (w_skid_ctrl),
        .o_data   (w_skid_data)
      );

      // Ready depends only on registered state, breaking the out_ready -> in_ready path.
      assign w_in_ready = !w_skid_valid && !flush;

      always_comb begin
        w_state_nxt    = r_state;
        w_main_load    = 1'b0;
        w_main_clear   = 1'b0;
        w_skid_load    = 1'b0;
        w_skid_clear   = 1'b0;
        w_main_ctrl_in = in_ctrl;
        w_main_data_in = in_data;
        if (flush) begin
          w_state_nxt = PL_EMPTY;
        end else begin
          case (r_state)
            PL_EMPTY: begin
              if (w_acc) begin
                w_main_load = 1'b1;
                w_state_nxt = PL_ONE;
              end
            end
            PL_ONE: begin
              if (w_acc && w_fire) begin
                w_main_load = 1'b1;
              end else if (w_acc) begin
                w_skid_load = 1'b1;
                w_state_nxt = PL_TWO;
              end else if (w_fire) begin
                w_main_clear = 1'b1;
                w_state_nxt  = PL_EMPTY;
              end
            end
            PL_TWO: begin
              if (w_fire) begin
                w_main_load    = 1'b1;
                w_main_ctrl_in = w_skid_ctrl;
                w_main_data_in = w_skid_data;
                w_skid_clear   = 1'b1;
                w_state_nxt    = PL_ONE;
              end
            end
            default: w_state_nxt = PL_EMPTY;
          endcase
        end
      end
    end else begin : g_single
      assign w_in_ready = (!w_main_valid || out_ready) && !flush;

      always_comb begin
        w_state_nxt    = r_state;
        w_main_load    = 1'b0;
        w_main_clear   = 1'b0;
        w_main_ctrl_in = in_ctrl;
        w_main_data_in = in_data;
        if (flush) begin
          w_state_nxt = PL_EMPTY;
        end else if (w_acc) begin
          w_main_load = 1'b1;
          w_state_nxt = PL_ONE;
        end else if (w_fire) begin
          w_main_clear = 1'b1;
          w_state_nxt  = PL_EMPTY;
        end
      end
    end
  endgenerate

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_main_valid && !out_ready && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
      if (!w_main_valid && !flush && (r_bubble_cnt != '1)) begin
        r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
      end
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = w_main_valid;
  // Masking here keeps a stale ctrl value from leaking out of an empty stage.
  assign out_ctrl   = w_main_valid ? w_main_ctrl : CTRL_RST;
  assign out_data   = w_main_data;
  assign occupancy  = pl_occ_t'(r_state);
  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_pl_stage_elastic.sv
// Bench for pl_stage_elastic: skid, single-entry and 4-bit-counter instances share one stimulus
// stream and are each compared every cycle against a queue-based reference model.
module tb_pl_stage_elastic;

  typedef struct packed {
    logic [7:0]   c;
    logic [127:0] d;
  } item_t;

  logic         CLK = 1'b0;
  logic         nRST;
  logic         in_valid;
  logic [7:0]   in_ctrl;
  logic [127:0] in_data;
  logic         out_ready;
  logic         flush;

  logic         in_ready_a, out_valid_a, in_ready_b, out_valid_b, in_ready_c, out_valid_c;
  logic [7:0]   out_ctrl_a, out_ctrl_b, out_ctrl_c;
  logic [127:0] out_data_a, out_data_b, out_data_c;
  logic [1:0]   occ_a, occ_b, occ_c;
  logic [31:0]  stall_a, bubble_a, stall_b, bubble_b;
  logic [3:0]   stall_c, bubble_c;

  int n_pass  = 0;
  int n_total = 0;

  item_t  qa[$];
  item_t  qb[$];
  longint sa, ba, sb, bb, sc, bc;

  always #5 CLK = ~CLK;

  pl_stage_elastic #(.CTRL_W(8), .DATA_W(128), .CTRL_RST(8'h00), .SKID(1), .CNT_W(32)) dut_a (
    .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(in_ready_a), .in_ctrl(in_ctrl),
    .in_data(in_data), .out_valid(out_valid_a), .out_ready(out_ready), .out_ctrl(out_ctrl_a),
    .out_data(out_data_a), .flush(flush), .occupancy(occ_a), .stall_cnt(stall_a),
    .bubble_cnt(bubble_a));

  pl_stage_elastic #(.CTRL_W(8), .DATA_W(128), .CTRL_RST(8'h00), .SKID(0), .CNT_W(32)) dut_b (
    .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(in_ready_b), .in_ctrl(in_ctrl),
    .in_data(in_data), .out_valid(out_valid_b), .out_ready(out_ready), .out_ctrl(out_ctrl_b),
    .out_data(out_data_b), .flush(flush), .occupancy(occ_b), .stall_cnt(stall_b),
    .bubble_cnt(bubble_b));

  pl_stage_elastic #(.CTRL_W(8), .DATA_W(128), .CTRL_RST(8'h00), .SKID(1), .CNT_W(4)) dut_c (
    .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(in_ready_c), .in_ctrl(in_ctrl),
    .in_data(in_data), .out_valid(out_valid_c), .out_ready(out_ready), .out_ctrl(out_ctrl_c),
    .out_data(out_data_c), .flush(flush), .occupancy(occ_c), .stall_cnt(stall_c),
    .bubble_cnt(bubble_c));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    qa.delete();
    qb.delete();
    sa = 0; ba = 0; sb = 0; bb = 0; sc = 0; bc = 0;
  endtask

  task automatic chk_reset_outputs(input string ph);
    chk({ph, "_a_valid"}, out_valid_a, 1'b0);
    chk({ph, "_a_ctrl"}, out_ctrl_a, 8'h00);
    chk({ph, "_a_data"}, out_data_a, 128'h0);
    chk({ph, "_a_occ"}, occ_a, 2'd0);
    chk({ph, "_a_stall"}, stall_a, 32'd0);
    chk({ph, "_a_bubble"}, bubble_a, 32'd0);
    chk({ph, "_b_valid"}, out_valid_b, 1'b0);
    chk({ph, "_b_occ"}, occ_b, 2'd0);
    chk({ph, "_c_stall"}, stall_c, 4'd0);
  endtask

  // One clock cycle: predict outputs from the model, compare, then advance the model.
  task automatic cycle();
    logic  va, vb, ra, rb;
    item_t ha, hb;
    #2;
    va = (qa.size() != 0);
    vb = (qb.size() != 0);
    ra = (qa.size() < 2) && !flush;
    rb = ((qb.size() == 0) || out_ready) && !flush;
    ha = va ? qa[0] : item_t'{c: 8'h00, d: 128'h0};
    hb = vb ? qb[0] : item_t'{c: 8'h00, d: 128'h0};
    chk("a_in_ready", in_ready_a, ra);
    chk("a_out_valid", out_valid_a, va);
    chk("a_out_ctrl", out_ctrl_a, ha.c);
    if (va) chk("a_out_data", out_data_a, ha.d);
    chk("a_occupancy", occ_a, qa.size());
    chk("a_stall_cnt", stall_a, sa);
    chk("a_bubble_cnt", bubble_a, ba);
    chk("b_in_ready", in_ready_b, rb);
    chk("b_out_valid", out_valid_b, vb);
    chk("b_out_ctrl", out_ctrl_b, hb.c);
    if (vb) chk("b_out_data", out_data_b, hb.d);
    chk("b_occupancy", occ_b, qb.size());
    chk("b_stall_cnt", stall_b, sb);
    chk("b_bubble_cnt", bubble_b, bb);
    chk("c_out_valid", out_valid_c, va);
    chk("c_stall_cnt", stall_c, sc);
    chk("c_bubble_cnt", bubble_c, bc);
    if (va && !out_ready && sa < 64'hFFFF_FFFF) sa++;
    if (!va && !flush && ba < 64'hFFFF_FFFF) ba++;
    if (vb && !out_ready && sb < 64'hFFFF_FFFF) sb++;
    if (!vb && !flush && bb < 64'hFFFF_FFFF) bb++;
    if (va && !out_ready && sc < 15) sc++;
    if (!va && !flush && bc < 15) bc++;
    if (flush) begin
      qa.delete();
      qb.delete();
    end else begin
      if (va && out_ready) void'(qa.pop_front());
      if (vb && out_ready) void'(qb.pop_front());
      if (in_valid && ra) qa.push_back(item_t'{c: in_ctrl, d: in_data});
      if (in_valid && rb) qb.push_back(item_t'{c: in_ctrl, d: in_data});
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] c, input logic [127:0] d,
                       input logic ordy, input logic fl);
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    cycle();
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    nRST = 1'b0;
    drive_init();
    repeat (3) @(posedge CLK);
    #1;
    chk_reset_outputs("rst");
    model_reset();
    nRST = 1'b1;

    // Streaming 1..10 at full rate
    for (int i = 1; i <= 10; i++) drive(1'b1, 8'hA5, 128'(i), 1'b1, 1'b0);
    repeat (2) drive(1'b0, 8'h00, 128'h0, 1'b1, 1'b0);
    chk("stream_a_stall_zero", stall_a, 32'd0);

    // Backpressure: 4 cycles of out_ready=0 while offering 3 items
    for (int i = 0; i < 3; i++) drive(1'b1, 8'h3C, 128'(100 + i), 1'b0, 1'b0);
    drive(1'b0, 8'h00, 128'h0, 1'b0, 1'b0);
    chk("bp_a_occ_full", occ_a, 2'd2);
    repeat (3) drive(1'b0, 8'h00, 128'h0, 1'b1, 1'b0);

    // Flush at occupancy 2 with an input in flight
    repeat (2) drive(1'b1, 8'h5A, rnd128(), 1'b0, 1'b0);
    drive(1'b1, 8'hEE, 128'hDEAD, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 128'h0, 1'b1, 1'b0);
    chk("flush_a_occ", occ_a, 2'd0);

    // out_ready toggling with a continuous source
    for (int i = 0; i < 8; i++) drive(1'b1, 8'h77, rnd128(), (i % 2) == 0, 1'b0);
    repeat (3) drive(1'b0, 8'h00, 128'h0, 1'b1, 1'b0);

    // Randomised traffic with occasional flushes
    for (int i = 0; i < 300; i++)
      drive($urandom_range(0, 3) != 0, 8'($urandom()), rnd128(),
            $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);

    // Asynchronous reset in the middle of a backed-up transfer
    repeat (3) drive(1'b1, 8'h11, rnd128(), 1'b0, 1'b0);
    #2;
    nRST = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    model_reset();
    @(posedge CLK);
    #1;
    nRST = 1'b1;

    // 4-bit counter saturation
    drive(1'b1, 8'h42, 128'h99, 1'b0, 1'b0);
    repeat (20) drive(1'b0, 8'h00, 128'h0, 1'b0, 1'b0);
    chk("sat_c_stall", stall_c, 4'hF);
    chk("sat_a_stall", stall_a, 32'd20);
    repeat (2) drive(1'b0, 8'h00, 128'h0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  task automatic drive_init();
    in_valid  = 1'b1;
    in_ctrl   = 8'hA5;
    in_data   = 128'h1234;
    out_ready = 1'b1;
    flush     = 1'b0;
  endtask

endmodule

// File: doc/pl_stage_elastic.md
Name: pl_stage_elastic

Overview:
- Parametrised successor to the fixed ID/EX-style pipeline latches: one generic pipeline stage register for IF/ID, ID/EX, EX/MEM and MEM/WB.
- Replaces the bare WEN/flush pair with a valid/ready handshake.
- Optional 2-entry skid buffer gives full throughput with a registered in_ready.
- Control and datapath fields are kept separate: flush squashes control only, so bubbles are harmless.
- Built-in stall/bubble performance counters.

Parameters:
- CTRL_W, 8, width of control bundle (WB/MEM/EX control bits); squashed on flush and when invalid.
- DATA_W, 128, width of datapath bundle (PC+4, rdat1/2, imm, reg ids); never squashed.
- CTRL_RST, '0, control value driven when empty or squashed (encodes a NOP).
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational ready.
- CNT_W, 32, width of performance counters.

Ports:
- CLK  input  1  clock, rising edge
- nRST  input  1  asynchronous active-low reset
- in_valid  input  1  upstream has an instruction
- in_ready  output  1  stage can accept this cycle
- in_ctrl  input  CTRL_W  upstream control bundle
- in_data  input  DATA_W  upstream datapath bundle
- out_valid  output  1  stage holds a valid instruction
- out_ready  input  1  downstream consumes this cycle
- out_ctrl  output  CTRL_W  control bundle, CTRL_RST when !out_valid
- out_data  output  DATA_W  datapath bundle, value undefined-but-stable when !out_valid
- flush  input  1  synchronous squash (branch/jump resolve)
- occupancy  output  2  entries held (0..2; max 1 when SKID=0)
- stall_cnt  output  CNT_W  cycles with out_valid && !out_ready
- bubble_cnt  output  CNT_W  cycles with !out_valid && !flush

Behaviour:
- Reset, asynchronous on nRST low:
  - all valids cleared; both ctrl registers set to CTRL_RST; data registers set to 0; counters set to 0.
  - Resulting outputs: out_valid=0, out_ctrl=CTRL_RST, out_data=0, occupancy=0; in_ready=1 once nRST is high.
- Events: acc = in_valid && in_ready; fire = out_valid && out_ready.
- SKID=1: entries main (drives outputs) and skid. States EMPTY, ONE, TWO; occupancy=0/1/2.
  - EMPTY: acc → ONE (main ← in).
  - ONE: acc && !fire → TWO (skid ← in). fire && !acc → EMPTY. acc && fire → ONE (main ← in).
  - TWO: fire → ONE (main ← skid); no accept is possible.
  - in_ready = !skid_valid && !flush (registered state only, no out_ready path).
- SKID=0: single entry main.
  - in_ready = (!main_valid || out_ready) && !flush.
  - acc loads main; fire && !acc clears main_valid.
- Latency: 1 cycle from acc to out_valid when the stage is empty. Throughput: 1 per cycle in both modes.
- flush has priority over everything:
  - both valids cleared next edge; both ctrl registers ← CTRL_RST; data registers retained.
  - in_ready=0 during flush, so the in-flight input is dropped.
  - fire in a flush cycle still counts as consumed downstream. The downstream stage treats its own flush independently.
- Data is never reset by flush; only valid and ctrl matter for correctness.
- out_ctrl = main_valid ? main_ctrl : CTRL_RST. This is combinational masking, so a stale ctrl never escapes.
- Counters:
  - increment per their definitions and saturate at all-ones (no wrap).
  - not cleared by flush; only nRST clears them.
  - a flush cycle adds nothing to bubble_cnt.
- Ordering is strict FIFO; the skid entry is never bypassed.
- Reset mid-transfer discards all held entries; no partial state survives.

Decomposition:
- Shared package pl_stage_pkg holds:
  - typedef pl_occ_t (logic [1:0])
  - enum pl_state_t {PL_EMPTY, PL_ONE, PL_TWO}
  - localparam for default counter width
  - CPU-specific ctrl bundle packing typedefs (wb_ctrl_t, mem_ctrl_t, ex_ctrl_t), so each stage instance sets CTRL_W from $bits.
- Sub-module pl_stage_slot: one entry of valid+ctrl+data with load/clear/squash, instantiated once (SKID=0) or twice (SKID=1).

Test Plan:
- Reset: hold nRST=0 with in_valid=1 → out_valid=0, out_ctrl=CTRL_RST, occupancy=0, counters 0. Release → in_ready=1 next cycle.
- Streaming, SKID=1, out_ready=1, in_valid=1 with ctrl=8'hA5 and data incrementing 1..10 → out_data emits 1..10 on consecutive cycles after 1-cycle latency; stall_cnt=0.
- Backpressure, SKID=1: out_ready=0 for 4 cycles while sending 3 items → 2 accepted, in_ready=0 after the second, occupancy=2, stall_cnt=3. Release → items emerge in order with no loss or duplication.
- Flush at occupancy=2 with in_valid=1 → next cycle out_valid=0, occupancy=0, out_ctrl=CTRL_RST; the flush-cycle input is absent at the output; bubble_cnt unchanged in the flush cycle.
- SKID=0 with out_ready toggling 1,0,1,0 → in_ready mirrors out_ready while full; every accepted item appears exactly once.
- Counter saturation with CNT_W=4: hold out_valid=1 and out_ready=0 for 20 cycles → stall_cnt stops at 4'hF.
